// File: rtl/key_command_encode.sv
// key_command_encode: turns the PS/2 Set-2 scan byte stream into display
// command codes. Tracks E0/F0 prefixes, suppresses typematic repeats of a
// held key (unless REPEAT_EN), and abandons prefix sequences that stall.
//
// Handshake: scanValid is a one-cycle strobe qualifying scanCode; there is
// no back-pressure. cmdValid is a one-cycle strobe qualifying cmdCode; the
// decoder must accept it in that cycle. protoErr is a one-cycle pulse and is
// never high together with cmdValid.
module key_command_encode #(
    parameter logic [7:0]  IDLE_CODE   = 8'hFF,
    parameter bit          REPEAT_EN   = 1'b0,
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] scanCode,
    input  logic       scanValid,
    output logic [7:0] cmdCode,
    output logic       cmdValid,
    output logic       protoErr,
    output logic [1:0] stateDbg
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_e;

    localparam logic [7:0] PFX_EXT = 8'hE0;
    localparam logic [7:0] PFX_BRK = 8'hF0;

    // The counter holds (cycles since the last byte - 1); at this value the
    // coming edge is the one where it would reach TIMEOUT_CYC-1.
    localparam logic [15:0] TMO_LAST = TIMEOUT_CYC - 16'd2;

    state_e      state_q;
    logic [15:0] tmo_cnt_q;
    logic [8:0]  held_q;
    logic        held_valid_q;
    logic [7:0]  cmd_code_q;
    logic        cmd_valid_q;
    logic        proto_err_q;

    logic        is_e0;
    logic        is_f0;
    logic        byte_final;
    logic        byte_ext;
    logic        byte_brk;
    logic [4:0]  map_res;
    logic        map_hit;
    logic [3:0]  map_cmd;
    logic        held_match;
    logic        make_emit;
    logic        break_clear;
    logic        tmo_expire;

    // Returns {hit, command} for an {ext, code} pair.
    function automatic logic [4:0] map_key(input logic ext, input logic [7:0] code);
        logic [4:0] r;
        r = 5'h00;
        if (!ext) begin
            case (code)
                8'h45:   r = 5'h10;
                8'h16:   r = 5'h11;
                8'h1E:   r = 5'h12;
                8'h26:   r = 5'h13;
                8'h2D:   r = 5'h14;
                8'h34:   r = 5'h15;
                8'h32:   r = 5'h16;
                8'h79:   r = 5'h1B;
                8'h7B:   r = 5'h1C;
                8'h2B:   r = 5'h1D;
                default: r = 5'h00;
            endcase
        end else begin
            case (code)
                8'h75:   r = 5'h17;
                8'h72:   r = 5'h18;
                8'h6B:   r = 5'h19;
                8'h74:   r = 5'h1A;
                default: r = 5'h00;
            endcase
        end
        return r;
    endfunction

    // Classify the incoming byte against the current prefix state and decide
    // whether it emits a command or releases the held key.
    always_comb begin
        is_e0      = (scanCode == PFX_EXT);
        is_f0      = (scanCode == PFX_BRK);
        byte_final = 1'b0;
        byte_ext   = 1'b0;
        byte_brk   = 1'b0;
        if (scanValid && !is_e0 && !is_f0) begin
            byte_final = 1'b1;
            case (state_q)
                ST_IDLE:    begin byte_ext = 1'b0; byte_brk = 1'b0; end
                ST_EXT:     begin byte_ext = 1'b1; byte_brk = 1'b0; end
                ST_BRK:     begin byte_ext = 1'b0; byte_brk = 1'b1; end
                ST_EXT_BRK: begin byte_ext = 1'b1; byte_brk = 1'b1; end
                default:    begin byte_ext = 1'b0; byte_brk = 1'b0; end
            endcase
        end
        map_res     = map_key(byte_ext, scanCode);
        map_hit     = map_res[4];
        map_cmd     = map_res[3:0];
        held_match  = held_valid_q && (held_q == {byte_ext, scanCode});
        make_emit   = byte_final && !byte_brk && map_hit && (REPEAT_EN || !held_match);
        break_clear = byte_final && byte_brk && held_match;
        tmo_expire  = (state_q != ST_IDLE) && (tmo_cnt_q == TMO_LAST);
    end

    // Prefix FSM, held-key tracking, timeout counter and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            tmo_cnt_q    <= '0;
            held_q       <= '0;
            held_valid_q <= 1'b0;
            cmd_code_q   <= IDLE_CODE;
            cmd_valid_q  <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            cmd_code_q  <= IDLE_CODE;
            cmd_valid_q <= 1'b0;
            proto_err_q <= 1'b0;
            if (scanValid) begin
                tmo_cnt_q <= '0;
                case (state_q)
                    ST_IDLE: begin
                        if (is_e0)      state_q <= ST_EXT;
                        else if (is_f0) state_q <= ST_BRK;
                        else            state_q <= ST_IDLE;
                    end
                    ST_EXT: begin
                        if (is_e0)      state_q <= ST_EXT;
                        else if (is_f0) state_q <= ST_EXT_BRK;
                        else            state_q <= ST_IDLE;
                    end
                    ST_BRK: begin
                        if (is_e0) begin
                            // Break before extend is out of order; keep the E0.
                            proto_err_q <= 1'b1;
                            state_q     <= ST_EXT;
                        end else if (is_f0) begin
                            state_q <= ST_BRK;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_EXT_BRK: begin
                        if (is_e0 || is_f0) proto_err_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
                if (make_emit) begin
                    cmd_code_q   <= {4'h0, map_cmd};
                    cmd_valid_q  <= 1'b1;
                    held_q       <= {byte_ext, scanCode};
                    held_valid_q <= 1'b1;
                end
                if (break_clear) begin
                    held_valid_q <= 1'b0;
                end
            end else if (state_q == ST_IDLE) begin
                tmo_cnt_q <= '0;
            end else if (tmo_expire) begin
                state_q     <= ST_IDLE;
                proto_err_q <= 1'b1;
                tmo_cnt_q   <= '0;
            end else begin
                tmo_cnt_q <= tmo_cnt_q + 16'd1;
            end
        end
    end

    assign cmdCode  = cmd_code_q;
    assign cmdValid = cmd_valid_q;
    assign protoErr = proto_err_q;
    assign stateDbg = state_q;

endmodule

// File: tb/tb_key_command_encode.sv
// Bench for key_command_encode: two instances (REPEAT_EN=0 and 1) share one
// randomized byte stream; a prefix/held-key model predicts every output cycle.
module tb_key_command_encode;

  localparam int TMO = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] scanCode = 8'h00;
  logic       scanValid = 1'b0;

  logic [7:0] cmd0, cmd1;
  logic       val0, val1, err0, err1;
  logic [1:0] st0, st1;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  key_command_encode #(.IDLE_CODE(8'hFF), .REPEAT_EN(1'b0), .TIMEOUT_CYC(16'd10)) dut0 (
    .clock(clock), .reset(reset), .scanCode(scanCode), .scanValid(scanValid),
    .cmdCode(cmd0), .cmdValid(val0), .protoErr(err0), .stateDbg(st0));

  key_command_encode #(.IDLE_CODE(8'hFF), .REPEAT_EN(1'b1), .TIMEOUT_CYC(16'd10)) dut1 (
    .clock(clock), .reset(reset), .scanCode(scanCode), .scanValid(scanValid),
    .cmdCode(cmd1), .cmdValid(val1), .protoErr(err1), .stateDbg(st1));

  // ---------------- reference model ----------------
  int         cmd_map[int];        // key = ext*256 + code -> command
  bit         m_ext[2], m_brk[2], m_held_v[2];
  int         m_held[2];
  int         m_elapsed[2];
  logic [7:0] exp_cmd[2];
  bit         exp_val[2], exp_err[2], exp_idle[2];
  logic [7:0] exp_q[$];            // command stream expected from dut0

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int cnt01_0 = 0, cnt01_1 = 0;
  int err_cyc = -1;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ext[i] = 0; m_brk[i] = 0; m_held_v[i] = 0; m_held[i] = 0; m_elapsed[i] = 0;
      exp_cmd[i] = 8'hFF; exp_val[i] = 0; exp_err[i] = 0; exp_idle[i] = 1;
    end
    exp_q.delete();
  endfunction

  function automatic void model_step(input bit v, input logic [7:0] c);
    int key;
    for (int i = 0; i < 2; i++) begin
      exp_cmd[i] = 8'hFF; exp_val[i] = 0; exp_err[i] = 0;
      if (v) begin
        m_elapsed[i] = 0;
        if (c == 8'hE0) begin
          if (m_ext[i] && m_brk[i]) begin exp_err[i] = 1; m_ext[i] = 0; m_brk[i] = 0; end
          else if (m_brk[i])        begin exp_err[i] = 1; m_ext[i] = 1; m_brk[i] = 0; end
          else                      m_ext[i] = 1;
        end else if (c == 8'hF0) begin
          if (m_ext[i] && m_brk[i]) begin exp_err[i] = 1; m_ext[i] = 0; m_brk[i] = 0; end
          else                      m_brk[i] = 1;
        end else begin
          key = (m_ext[i] ? 256 : 0) + int'(c);
          if (m_brk[i]) begin
            if (m_held_v[i] && m_held[i] == key) m_held_v[i] = 0;
          end else if (cmd_map.exists(key)) begin
            if (i == 1 || !(m_held_v[i] && m_held[i] == key)) begin
              exp_cmd[i] = 8'(cmd_map[key]); exp_val[i] = 1;
              m_held[i] = key; m_held_v[i] = 1;
              if (i == 0) exp_q.push_back(8'(cmd_map[key]));
            end
          end
          m_ext[i] = 0; m_brk[i] = 0;
        end
      end else if (m_ext[i] || m_brk[i]) begin
        m_elapsed[i]++;
        if (m_elapsed[i] == TMO - 1) begin
          exp_err[i] = 1; m_ext[i] = 0; m_brk[i] = 0;
        end
      end
      exp_idle[i] = !(m_ext[i] || m_brk[i]);
    end
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check_outputs();
    check("cmd0", cmd0, exp_cmd[0]);
    check("val0", val0, exp_val[0]);
    check("err0", err0, exp_err[0]);
    check("idle0", st0 == 2'd0, exp_idle[0]);
    check("cmd1", cmd1, exp_cmd[1]);
    check("val1", val1, exp_val[1]);
    check("err1", err1, exp_err[1]);
    check("idle1", st1 == 2'd0, exp_idle[1]);
    if (val0) begin
      if (exp_q.size() == 0) check("sb_extra", {24'h0, cmd0}, 32'hFFFF_FFFF);
      else                   check("sb_cmd0", cmd0, exp_q.pop_front());
      if (cmd0 == 8'h01) cnt01_0++;
    end
    if (val1 && cmd1 == 8'h01) cnt01_1++;
    if (err0) begin err_cyc = cyc; err_cnt++; end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit v, input logic [7:0] c);
    @(negedge clock);
    cyc++;
    check_outputs();
    scanValid = v;
    scanCode  = c;
    model_step(v, c);
  endtask

  task automatic send(input logic [7:0] c);
    cycle(1'b1, c);
    cycle(1'b0, 8'h00);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 8'h00);
  endtask

  task automatic apply_reset(input int n);
    @(negedge clock);
    cyc++;
    check_outputs();
    scanValid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("rst_cmd0", cmd0, 8'hFF);
    check("rst_val0", val0, 1'b0);
    check("rst_err0", err0, 1'b0);
    check("rst_st0", st0, 2'd0);
    check("rst_cmd1", cmd1, 8'hFF);
    check("rst_val1", val1, 1'b0);
    model_reset();
    repeat (n) @(negedge clock);
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] pool[16] = '{8'hE0, 8'hF0, 8'h45, 8'h16, 8'h1E, 8'h26, 8'h2D, 8'h34,
                           8'h32, 8'h79, 8'h7B, 8'h2B, 8'h75, 8'h72, 8'h6B, 8'h74};

  initial begin
    int s;
    logic [7:0] b;
    cmd_map[8'h45] = 0;  cmd_map[8'h16] = 1;  cmd_map[8'h1E] = 2;  cmd_map[8'h26] = 3;
    cmd_map[8'h2D] = 4;  cmd_map[8'h34] = 5;  cmd_map[8'h32] = 6;
    cmd_map[8'h79] = 11; cmd_map[8'h7B] = 12; cmd_map[8'h2B] = 13;
    cmd_map[256 + 8'h75] = 7; cmd_map[256 + 8'h72] = 8;
    cmd_map[256 + 8'h6B] = 9; cmd_map[256 + 8'h74] = 10;
    model_reset();

    repeat (3) @(negedge clock);
    check("por_cmd0", cmd0, 8'hFF);
    check("por_val0", val0, 1'b0);
    check("por_err0", err0, 1'b0);
    reset = 1'b1;

    // single make
    send(8'h2D); idle(2);
    // extended make then extended break; plain 75 is unmapped
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    send(8'h75); idle(2);

    // typematic repeat handling
    cnt01_0 = 0; cnt01_1 = 0;
    send(8'h16); send(8'h16); send(8'h16); send(8'hF0); send(8'h16); send(8'h16);
    idle(2);
    check("rep0_count", cnt01_0, 2);
    check("rep1_count", cnt01_1, 4);

    // prefix timeout, then a byte parsed from IDLE
    err_cnt = 0;
    cycle(1'b1, 8'hE0);
    s = cyc;
    idle(12);
    check("tmo_pulses", err_cnt, 1);
    check("tmo_latency", err_cyc - s, TMO);
    send(8'h74); idle(2);

    // illegal prefix orders
    send(8'hF0); send(8'hE0); send(8'h6B);
    send(8'hE0); send(8'hF0); send(8'hF0); idle(2);

    // reset mid-sequence
    cycle(1'b1, 8'hE0);
    apply_reset(2);
    send(8'h72); send(8'h45); idle(2);

    // randomized byte stream with gaps around the timeout boundary
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 7) == 0) b = 8'($urandom_range(0, 255));
      else                           b = pool[$urandom_range(0, 15)];
      cycle(1'b1, b);
      idle($urandom_range(1, 11));
      if ($urandom_range(0, 99) == 0) apply_reset($urandom_range(1, 3));
    end

    idle(3);
    check("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_command_encode.md
Name: key_command_encode

Overview:
- Converts the PS/2 Set-2 scan-code byte stream from the keyboard receiver into the 8-bit command codes consumed by the display command decoder.
- Handles the E0 (extended) and F0 (break) prefixes, suppresses typematic repeats, and times out incomplete prefix sequences.
- Drives exactly one command code per accepted key press; otherwise drives the idle code, which the decoder ignores.

Parameters:
- IDLE_CODE, 8'hFF, value driven on cmdCode when no command is issued; must lie outside 8'h00..8'h0D.
- REPEAT_EN, 0, 1 = every typematic make code emits a command; 0 = a held key emits once until released.
- TIMEOUT_CYC, 16'd50000, clock cycles allowed between a prefix byte and the next byte before the sequence is abandoned (must be >= 2).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- scanCode  input  8  scan byte from the PS/2 receiver, valid only while scanValid=1.
- scanValid  input  1  one-cycle strobe per received byte.
- cmdCode  output  8  command code to the decoder; IDLE_CODE except during a command cycle.
- cmdValid  output  1  high for exactly the one cycle cmdCode carries a command.
- protoErr  output  1  one-cycle pulse on prefix timeout or illegal prefix order.

Behaviour:
- Reset (reset=0, asynchronous): cmdCode=IDLE_CODE, cmdValid=0, protoErr=0, state=IDLE, heldValid=0, timeout counter=0.
- All outputs are registered. A final byte strobed in cycle N produces cmdCode/cmdValid in cycle N+1, for one cycle only.
- Command map, non-extended:
  - 45→00, 16→01, 1E→02, 26→03 (digits 0–3)
  - 2D→04 (R), 34→05 (G), 32→06 (B)
  - 79→0B (keypad +), 7B→0C (keypad −)
  - 2B→0D (F)
- Command map, extended (E0 prefix): 75→07 (up), 72→08 (down), 6B→09 (left), 74→0A (right).
- Any other {ext,code} pair is unmapped: no command, no error. Non-extended 75/72/6B/74 are unmapped.
- State machine, states IDLE, EXT, BRK, EXT_BRK:
  - IDLE: E0→EXT; F0→BRK; other byte = make, non-extended.
  - EXT: F0→EXT_BRK; E0→stay EXT; other byte = make, extended, →IDLE.
  - BRK: E0→protoErr pulse, →EXT; F0→stay BRK; other byte = break, non-extended, →IDLE.
  - EXT_BRK: E0 or F0→protoErr pulse, →IDLE; other byte = break, extended, →IDLE.
- Held-key tracking: register held = {ext, code}, flag heldValid.
  - On a mapped make: if REPEAT_EN=0, heldValid=1 and held matches, the make is suppressed. Otherwise emit the command, set held to the new pair, and set heldValid=1.
  - On a break matching held: heldValid=0. A non-matching break is ignored.
  - Unmapped makes do not change held.
- Timeout:
  - The counter clears on every scanValid and whenever state=IDLE, and increments each cycle in any other state.
  - When it reaches TIMEOUT_CYC−1 with no scanValid in that cycle: →IDLE, protoErr pulse, counter clears.
  - If scanValid coincides with the expiry cycle, the byte is processed normally and no timeout occurs.
- Bytes arrive at most once every 2 cycles. Back-to-back strobes are still each processed in order; there is no buffering beyond the state register.
- Reset asserted mid-sequence discards the partial prefix and the held key. The first byte after release is parsed from IDLE.
- protoErr and cmdValid are never high in the same cycle: error paths never emit a command.

Test Plan:
- Reset release, then strobe 2D → one cycle later cmdCode=04 and cmdValid=1 for 1 cycle, then cmdCode=FF and cmdValid=0.
- Strobe E0,75 then E0,F0,75 → one command 07 after the 75 make; the break emits nothing and clears held. Non-extended 75 alone → no command.
- REPEAT_EN=0: strobe 16,16,16,F0,16,16 → exactly two 01 commands, one after the first 16 and one after the last. With REPEAT_EN=1 the same stimulus gives four 01 commands.
- TIMEOUT_CYC=10: strobe E0 with no further byte → protoErr pulses 9 cycles after the E0 cycle and state returns to IDLE. Strobe 74 immediately after → no command, because it is parsed as non-extended (unmapped).
- Strobe F0,E0,6B → protoErr pulse after the E0, then command 09 after the 6B. Strobe E0,F0,F0 → protoErr pulse, no command.
- Assert reset between E0 and 72 → outputs return to reset values immediately. After release, 72 alone gives no command and 45 gives command 00.
